output_control_unit: RTL and testbench
======================================

Name: output_control_unit

Overview:
- Write-side counterpart of the tile input unit.
- Accepts output tiles from the PE (MO x MO signed accumulators, where MO = INPUT_TILE_SIZE - KERNEL_SIZE + 1), requantizes each value to 8-bit unsigned, and re-serializes them into a raster-order pixel stream of the OW x OW output feature map.
- Uses ping-pong tile-row buffers so the PE can fill one tile row while the other drains under downstream backpressure.

Parameters:
- KERNEL_SIZE, 3, convolution kernel edge.
- INPUT_IMAGE_WIDTH, 10, input image edge W; output edge OW = W - KERNEL_SIZE + 1.
- INPUT_TILE_SIZE, 4, input tile edge n; output tile edge MO = n - KERNEL_SIZE + 1.
- ACC_WIDTH, 29, width of each signed PE accumulator (KERNEL_DATA_WIDTH + INPUT_DATA_WIDTH + 13).
- SHIFT, 8, arithmetic right shift applied before saturation.
- Legal configurations require OW % MO == 0; TPR = OW / MO is the number of tiles per tile row.

Ports:
- clk  input  1  system clock, all logic on rising edge.
- reset  input  1  asynchronous, active-low reset.
- i_tile_data  input  MO*MO*ACC_WIDTH  signed tile; element (r,c) at bits [(r*MO+c)*ACC_WIDTH +: ACC_WIDTH].
- i_tile_valid  input  1  tile present on i_tile_data.
- o_tile_ready  output  1  block can accept a tile; transfer occurs when i_tile_valid && o_tile_ready at a rising edge.
- o_pixel_data  output  8  requantized output pixel.
- o_pixel_valid  output  1  o_pixel_data valid.
- i_pixel_ready  input  1  downstream accepts; transfer occurs when o_pixel_valid && i_pixel_ready.
- o_frame_done  output  1  one-cycle pulse after the last pixel of the frame transfers.

Behaviour:
- Reset (reset=0, async): o_pixel_data=0, o_pixel_valid=0, o_frame_done=0, o_tile_ready=1; both banks empty; wr_bank=rd_bank=0; all counters 0.
- Storage: two banks, each MO*OW entries of 8 bits. Values are requantized on write.
- Requantize: y = acc >>> SHIFT (sign-preserving). If y < 0 output 0; if y > 255 output 255; otherwise y[7:0].
- Write side: o_tile_ready = !full[wr_bank] (combinational from registered state).
  - On a tile transfer with tile-column counter tc, element (r,c) is written to wr_bank at row r, column tc*MO + c.
  - tc increments on each transfer. On tc == TPR-1: set full[wr_bank], toggle wr_bank, tc wraps to 0.
- Read side FSM, states IDLE, STREAM, DONE:
  - IDLE: when full[rd_bank], load the first pixel (row 0, col 0), assert o_pixel_valid, and enter STREAM. First valid appears one cycle after the bank's full flag sets, i.e. two edges after the last tile transfer of that tile row.
  - STREAM: pixels go out row-major, rows 0..MO-1, cols 0..OW-1.
    - While o_pixel_valid && !i_pixel_ready, o_pixel_data is held stable.
    - On each transfer, present the next pixel on the following cycle with no bubble.
    - On transfer of the last pixel of the bank: clear full[rd_bank], toggle rd_bank, increment tile-row counter tr.
      - If tr was OW/MO - 1: go to DONE, tr wraps to 0.
      - Else if the other bank is already full: continue streaming with no bubble.
      - Else: drop o_pixel_valid and return to IDLE.
  - DONE: pulse o_frame_done for exactly one cycle with o_pixel_valid=0, then go to IDLE.
- Simultaneous events: the write side setting full on one bank and the read side clearing full on the other bank in the same cycle are both honoured. A tile accepted in the same cycle a bank frees is legal only into the bank that was already empty; readiness always reflects state before the edge.
- Backpressure: with both banks full, o_tile_ready=0 until the read side frees a bank. No tile or pixel is ever dropped or duplicated.
- The next frame starts without any reset; counters continue from 0.
- Reset mid-operation: all buffered data is discarded and the block returns to the reset state immediately.

Test Plan:
- Reset -> o_tile_ready=1, o_pixel_valid=0, o_pixel_data=0, o_frame_done=0; release reset, hold idle 10 cycles -> outputs unchanged.
- Defaults (MO=2, OW=8, TPR=4), i_pixel_ready=1; feed 4 tiles with acc(r,c) = (r*8 + tc*2 + c) << 8 -> 16 consecutive valid pixels with values 0,1,...,15; first valid two edges after the 4th tile transfer.
- Requantize: tile elements -5, 511, 300<<8, 0x0FFFFFFF -> outputs 0, 1, 255, 255.
- Backpressure: deassert i_pixel_ready for 3 cycles while pixel 5 is presented -> o_pixel_data stays 5; sequence resumes 5,6,7... with no gap or duplicate.
- Ping-pong full: i_pixel_ready=0, offer tiles continuously -> 8 tiles accepted, o_tile_ready=0 afterward; raise i_pixel_ready -> tile 9 is accepted after the 16th pixel transfers.
- Full frame: 16 tiles -> 64 pixels in raster order, o_frame_done high for exactly one cycle after the 64th transfer. Assert reset mid-frame, then restart -> first pixel after restart equals the new frame's pixel (0,0).

Source files
------------

// File: rtl/output_control_unit.sv
// Requantizes PE output tiles into ping-pong tile-row banks and streams them as raster pixels.
// First pixel appears one cycle after a bank fills; pixel data holds under i_pixel_ready=0, and tiles stall while both banks are full.
module output_control_unit #(
  parameter int KERNEL_SIZE       = 3,
  parameter int INPUT_IMAGE_WIDTH = 10,
  parameter int INPUT_TILE_SIZE   = 4,
  parameter int ACC_WIDTH         = 29,
  parameter int SHIFT             = 8,
  localparam int MO               = INPUT_TILE_SIZE - KERNEL_SIZE + 1
) (
  input  logic                        clk,
  input  logic                        reset,
  input  logic [MO*MO*ACC_WIDTH-1:0]  i_tile_data,
  input  logic                        i_tile_valid,
  output logic                        o_tile_ready,
  output logic [7:0]                  o_pixel_data,
  output logic                        o_pixel_valid,
  input  logic                        i_pixel_ready,
  output logic                        o_frame_done
);
  localparam int OW    = INPUT_IMAGE_WIDTH - KERNEL_SIZE + 1;
  localparam int TPR   = OW / MO;
  localparam int DEPTH = MO * OW;
  localparam int IW    = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CW    = (TPR > 1) ? $clog2(TPR) : 1;

  typedef enum logic [1:0] {IDLE, STREAM, DONE} state_t;

  state_t          state_q, state_d;
  logic [7:0]      mem_q [2][DEPTH];
  logic [1:0]      full_q, full_d;
  logic            wr_bank_q;
  logic            rd_bank_q, rd_bank_d;
  logic [CW-1:0]   tc_q;
  logic [CW-1:0]   tr_q, tr_d;
  logic [IW-1:0]   idx_q, idx_d;
  logic [IW-1:0]   col_base;
  logic [7:0]      pix_q, pix_d;
  logic            vld_q, vld_d;
  logic            tile_xfer, tile_last, pix_xfer, pix_last;

  // Arithmetic shift keeps the sign, so the sign bit alone decides the low clamp.
  function automatic logic [7:0] requant(input logic signed [ACC_WIDTH-1:0] acc);
    logic signed [ACC_WIDTH-1:0] y;
    logic [7:0]                  res;
    y = acc >>> SHIFT;
    if (y[ACC_WIDTH-1])        res = 8'd0;
    else if (|y[ACC_WIDTH-2:8]) res = 8'hFF;
    else                        res = y[7:0];
    return res;
  endfunction

  assign o_tile_ready  = !full_q[wr_bank_q];
  assign tile_xfer     = i_tile_valid && o_tile_ready;
  assign tile_last     = (tc_q == CW'(TPR - 1));
  assign pix_xfer      = vld_q && i_pixel_ready;
  assign pix_last      = (idx_q == IW'(DEPTH - 1));
  assign col_base      = IW'(int'(tc_q) * MO);
  assign o_pixel_data  = pix_q;
  assign o_pixel_valid = vld_q;
  assign o_frame_done  = (state_q == DONE);

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      tc_q      <= '0;
      wr_bank_q <= 1'b0;
    end else if (tile_xfer) begin
      tc_q <= tile_last ? '0 : tc_q + CW'(1);
      if (tile_last) wr_bank_q <= ~wr_bank_q;
    end
  end

  always_ff @(posedge clk) begin
    if (tile_xfer) begin
      for (int r = 0; r < MO; r++) begin
        for (int c = 0; c < MO; c++) begin
          mem_q[wr_bank_q][col_base + IW'(r * OW + c)] <=
            requant(i_tile_data[(r*MO+c)*ACC_WIDTH +: ACC_WIDTH]);
        end
      end
    end
  end

  // The two banks never collide: a set targets an empty bank, a clear targets a full one.
  always_comb begin
    state_d   = state_q;
    full_d    = full_q;
    rd_bank_d = rd_bank_q;
    tr_d      = tr_q;
    idx_d     = idx_q;
    pix_d     = pix_q;
    vld_d     = vld_q;
    if (tile_xfer && tile_last) full_d[wr_bank_q] = 1'b1;
    case (state_q)
      IDLE: begin
        if (full_q[rd_bank_q]) begin
          idx_d   = '0;
          pix_d   = mem_q[rd_bank_q][0];
          vld_d   = 1'b1;
          state_d = STREAM;
        end
      end
      STREAM: begin
        if (pix_xfer) begin
          if (!pix_last) begin
            idx_d = idx_q + IW'(1);
            pix_d = mem_q[rd_bank_q][idx_q + IW'(1)];
          end else begin
            full_d[rd_bank_q] = 1'b0;
            rd_bank_d         = ~rd_bank_q;
            idx_d             = '0;
            if (tr_q == CW'(TPR - 1)) begin
              tr_d    = '0;
              vld_d   = 1'b0;
              state_d = DONE;
            end else begin
              tr_d = tr_q + CW'(1);
              if (full_q[~rd_bank_q]) begin
                pix_d = mem_q[~rd_bank_q][0];
              end else begin
                vld_d   = 1'b0;
                state_d = IDLE;
              end
            end
          end
        end
      end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q   <= IDLE;
      full_q    <= '0;
      rd_bank_q <= 1'b0;
      tr_q      <= '0;
      idx_q     <= '0;
      pix_q     <= '0;
      vld_q     <= 1'b0;
    end else begin
      state_q   <= state_d;
      full_q    <= full_d;
      rd_bank_q <= rd_bank_d;
      tr_q      <= tr_d;
      idx_q     <= idx_d;
      pix_q     <= pix_d;
      vld_q     <= vld_d;
    end
  end
endmodule

// File: tb/tb_output_control_unit.sv
// Scoreboard bench: frames are built as whole images, expected pixels queued in raster order, monitor pops on transfers.
module tb_output_control_unit;
  localparam int K = 3, W = 10, N = 4, ACCW = 29, SH = 8;
  localparam int MO = N - K + 1, OW = W - K + 1, TPR = OW / MO, FRAME = OW * OW;

  logic                   clk = 1'b0;
  logic                   reset = 1'b0;
  logic [MO*MO*ACCW-1:0]  i_tile_data = '0;
  logic                   i_tile_valid = 1'b0;
  logic                   o_tile_ready;
  logic [7:0]             o_pixel_data;
  logic                   o_pixel_valid;
  logic                   i_pixel_ready = 1'b1;
  logic                   o_frame_done;

  int          n_checks = 0, n_fail = 0;
  int unsigned exp_q[$];
  longint      img[OW][OW];
  int          rdy_mode = 0, stall_cnt = 0;
  bit          stall_done = 0;
  int          xfers = 0, frame_pix = 0;
  bit          hold_pend = 0, done_exp = 0;
  logic [7:0]  hold_dat;
  int unsigned e;
  int          x0;

  always #5 clk = ~clk;

  output_control_unit #(
    .KERNEL_SIZE(K), .INPUT_IMAGE_WIDTH(W), .INPUT_TILE_SIZE(N), .ACC_WIDTH(ACCW), .SHIFT(SH)
  ) dut (
    .clk(clk), .reset(reset),
    .i_tile_data(i_tile_data), .i_tile_valid(i_tile_valid), .o_tile_ready(o_tile_ready),
    .o_pixel_data(o_pixel_data), .o_pixel_valid(o_pixel_valid), .i_pixel_ready(i_pixel_ready),
    .o_frame_done(o_frame_done)
  );

  task automatic check(input string name, input longint act, input longint exp);
    n_checks++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Floor division by 2^SH, then clamp to [0,255].
  function automatic int ref_pix(input longint acc);
    longint q;
    if (acc < 0) return 0;
    q = acc / (longint'(1) << SH);
    return (q > 255) ? 255 : int'(q);
  endfunction

  function automatic longint rand_acc();
    longint v;
    case ($urandom % 4)
      0: begin
        v = longint'($urandom & 32'h1FFF_FFFF);
        if (v >= (longint'(1) << 28)) v = v - (longint'(1) << 29);
      end
      1: v = longint'($urandom_range(0, 65535));
      2: v = -longint'($urandom_range(1, 1000));
      default: v = longint'($urandom_range(0, 300 * 256));
    endcase
    return v;
  endfunction

  task automatic gen_frame(input int mode);
    for (int y = 0; y < OW; y++)
      for (int x = 0; x < OW; x++)
        img[y][x] = (mode == 0) ? (longint'(y * OW + x) << SH) : rand_acc();
    if (mode == 1) begin
      img[0][0] = -5;
      img[0][1] = 511;
      img[1][0] = longint'(300) << 8;
      img[1][1] = longint'(32'h0FFF_FFFF);
    end
    for (int y = 0; y < OW; y++)
      for (int x = 0; x < OW; x++)
        exp_q.push_back(ref_pix(img[y][x]));
  endtask

  // Entered and left at posedge+1; waits (bounded) for readiness at the negedge.
  task automatic send_tile(input int t);
    int cyc = 0;
    int tr = t / TPR;
    int tc = t % TPR;
    for (int r = 0; r < MO; r++)
      for (int c = 0; c < MO; c++)
        i_tile_data[(r*MO+c)*ACCW +: ACCW] = ACCW'(img[tr*MO+r][tc*MO+c]);
    i_tile_valid = 1'b1;
    @(negedge clk);
    while (!o_tile_ready && cyc < 300) begin
      @(negedge clk);
      cyc++;
    end
    check("tile_ready_seen", o_tile_ready, 1);
    @(posedge clk);
    #1 i_tile_valid = 1'b0;
  endtask

  task automatic send_range(input int from, input int to, input bit gaps);
    for (int t = from; t < to; t++) begin
      send_tile(t);
      if (gaps) repeat ($urandom % 3) begin @(posedge clk); #1; end
    end
  endtask

  task automatic drain();
    int cyc = 0;
    while (exp_q.size() != 0 && cyc < 2000) begin
      @(posedge clk);
      cyc++;
    end
    repeat (3) @(posedge clk);
    #1;
    check("queue_drained", exp_q.size(), 0);
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, "_tile_ready"}, o_tile_ready, 1);
    check({tag, "_pixel_valid"}, o_pixel_valid, 0);
    check({tag, "_pixel_data"}, o_pixel_data, 0);
    check({tag, "_frame_done"}, o_frame_done, 0);
  endtask

  // Pixel-ready driver, updated at posedge+2 so it sees mode changes made at posedge+1.
  initial forever begin
    @(posedge clk);
    #2;
    case (rdy_mode)
      0: i_pixel_ready = 1'b1;
      1: i_pixel_ready = ($urandom % 4) != 0;
      2: i_pixel_ready = 1'b0;
      default: begin
        if (stall_cnt > 0) begin
          i_pixel_ready = 1'b0;
          stall_cnt--;
        end else if (!stall_done && o_pixel_valid && o_pixel_data == 8'd5) begin
          i_pixel_ready = 1'b0;
          stall_cnt = 2;
          stall_done = 1;
        end else begin
          i_pixel_ready = 1'b1;
        end
      end
    endcase
  end

  // Monitor: a valid&&ready seen at the negedge transfers at the next posedge.
  initial forever begin
    @(negedge clk);
    if (!reset) begin
      hold_pend = 0;
      done_exp  = 0;
      frame_pix = 0;
    end else begin
      if (hold_pend) begin
        check("hold_valid", o_pixel_valid, 1);
        check("hold_data", o_pixel_data, hold_dat);
      end
      if (done_exp || o_frame_done) begin
        check("frame_done", o_frame_done, done_exp);
        if (done_exp) check("valid_during_done", o_pixel_valid, 0);
      end
      done_exp  = 0;
      hold_pend = o_pixel_valid && !i_pixel_ready;
      hold_dat  = o_pixel_data;
      if (o_pixel_valid && i_pixel_ready) begin
        xfers++;
        if (exp_q.size() == 0) begin
          check("unexpected_pixel", o_pixel_valid, 0);
        end else begin
          e = exp_q.pop_front();
          check("pixel", o_pixel_data, e);
        end
        frame_pix++;
        if (frame_pix == FRAME) begin
          frame_pix = 0;
          done_exp  = 1;
        end
      end
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish, checks=%0d", n_checks);
    $fatal(1);
  end

  initial begin
    repeat (3) @(posedge clk);
    @(negedge clk);
    check_reset_outputs("reset");
    @(posedge clk);
    #1 reset = 1'b1;
    repeat (10) @(negedge clk);
    check_reset_outputs("idle");
    @(posedge clk);
    #1;

    // Frame A: ramp pattern, first-valid latency, 3-cycle stall on pixel 5.
    rdy_mode = 3;
    gen_frame(0);
    send_range(0, TPR, 0);
    @(negedge clk);
    check("first_valid_early", o_pixel_valid, 0);
    @(negedge clk);
    check("first_valid", o_pixel_valid, 1);
    check("first_pixel", o_pixel_data, 0);
    @(posedge clk);
    #1;
    send_range(TPR, TPR * TPR, 0);
    drain();

    // Frame B: saturation corners plus random values, random backpressure and tile gaps.
    rdy_mode = 1;
    gen_frame(1);
    send_range(0, TPR * TPR, 1);
    drain();

    // Frame C: both banks fill while the sink stalls.
    rdy_mode = 2;
    @(posedge clk);
    #1;
    gen_frame(2);
    send_range(0, 2 * TPR, 0);
    repeat (5) begin
      @(negedge clk);
      check("tile_ready_both_full", o_tile_ready, 0);
    end
    check("stalled_valid", o_pixel_valid, 1);
    @(posedge clk);
    #1;
    x0 = xfers;
    rdy_mode = 0;
    send_tile(2 * TPR);
    check("tile9_pixels_before", xfers - x0, 2 * OW + 1);
    send_range(2 * TPR + 1, TPR * TPR, 0);
    drain();

    // Frame D aborted by reset, then frame E from scratch.
    rdy_mode = 1;
    gen_frame(2);
    send_range(0, TPR + 2, 0);
    repeat (4) begin @(posedge clk); #1; end
    reset = 1'b0;
    exp_q.delete();
    #1;
    check_reset_outputs("midreset");
    @(posedge clk);
    #1 reset = 1'b1;
    @(posedge clk);
    #1;
    rdy_mode = 0;
    gen_frame(2);
    send_range(0, TPR * TPR, 1);
    drain();

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
